led_chain_rx: RTL

Receive-side counterpart of the LED shift-chain driver. It samples the TLC5955-style serial chain (SCLK, LAT, 2×NUM_SHIFT_CHANNEL data lanes) in the spiClk domain and deserializes each lane's 48-bit {B,G,R} words. Each word is written into a capture RAM, and the block flags framing errors. It serves as an in-FPGA loopback checker and readback path for the LED display pipeline.

---
 rtl/led_chain_pkg.sv | 20 ++
 rtl/led_chain_rx_if.sv | 16 +
 rtl/led_lane_deser.sv | 37 +++
 rtl/led_chain_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/led_chain_pkg.sv
// rtl/led_chain_pkg.sv - shared LED chain constants and receiver state type
package led_chain_pkg;

  localparam int LED_WORD_W     = 48;
  localparam int WORDS_PER_CHIP = 16;
  localparam int WORDS_PER_LANE = 32;
  localparam int BITS_PER_FRAME = 1538;

  localparam int BIT_CNT_W  = 11;
  localparam int WORD_CNT_W = 5;
  localparam int POS_W      = 6;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    DATA,
    FULL
  } rx_state_t;

endpackage

// File: rtl/led_chain_rx_if.sv
// rtl/led_chain_rx_if.sv - capture RAM write port of the chain receiver
interface led_chain_rx_if #(
  parameter int NUM_SHIFT_CHANNEL = 4
);
  import led_chain_pkg::*;

  localparam int LANE_W = $clog2(2 * NUM_SHIFT_CHANNEL);

  logic                  wrEn;
  logic [LANE_W+4:0]     wrAddr;
  logic [LED_WORD_W-1:0] wrData;

  modport master (output wrEn, output wrAddr, output wrData);
  modport slave  (input  wrEn, input  wrAddr, input  wrData);

endinterface

// File: rtl/led_lane_deser.sv
// rtl/led_lane_deser.sv - per-lane 48-bit MSB-first deserializer with parallel capture
module led_lane_deser
  import led_chain_pkg::*;
(
  input  logic                  spiClk,
  input  logic                  nReset,
  input  logic                  shift_en,
  input  logic                  capture,
  input  logic                  sdi,
  output logic [LED_WORD_W-1:0] word
);

  // Only 47 bits are stored; the 48th is the bit arriving with the capture strobe.
  logic [LED_WORD_W-2:0] sr;
  logic [LED_WORD_W-1:0] sr_next;

  assign sr_next = {sr, sdi};

  // Shift one received bit in per data bit event
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= sr_next[LED_WORD_W-2:0];
    end
  end

  // Hold the completed word (including the in-flight last bit) for the drain
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      word <= '0;
    end else if (capture) begin
      word <= sr_next;
    end
  end

endmodule

// File: rtl/led_chain_rx.sv
// rtl/led_chain_rx.sv - LED shift-chain receiver: deserialize lanes into capture RAM, flag framing errors
module led_chain_rx
  import led_chain_pkg::*;
#(
  parameter  int NUM_SHIFT_CHANNEL = 4,
  localparam int LANES  = 2 * NUM_SHIFT_CHANNEL,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic              spiClk,
  input  logic              nReset,
  input  logic              SCLK_in,
  input  logic              LAT_in,
  input  logic [LANES-1:0]  SDIs,
  led_chain_rx_if.master    wr,
  output logic              busy,
  output logic              frameDone,
  output logic              frameErr,
  output logic              selErr
);

  logic sclk_q, sclk_d, lat_q, lat_d;
  logic [LANES-1:0] sdi_q;
  logic bit_ev, lat_ev;

  rx_state_t state, state_nxt;
  logic shift_en, capture, sel_chk, start, overrun;

  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [POS_W-1:0]      pos;
  logic                  err_nxt, sel_nxt;

  logic                  drain_act;
  logic [LANE_W-1:0]     drain_lane;
  logic [WORD_CNT_W-1:0] drain_word;
  logic [LED_WORD_W-1:0] lane_word [LANES];

  // Register the chain inputs once and keep the previous SCLK/LAT for edge detection
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      sclk_q <= 1'b0;
      sclk_d <= 1'b0;
      lat_q  <= 1'b0;
      lat_d  <= 1'b0;
      sdi_q  <= '0;
    end else begin
      sclk_q <= SCLK_in;
      sclk_d <= sclk_q;
      lat_q  <= LAT_in;
      lat_d  <= lat_q;
      sdi_q  <= SDIs;
    end
  end

  assign bit_ev = sclk_q & ~sclk_d;
  assign lat_ev = lat_q & ~lat_d;

  // State register
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-bit strobes; the frame-start bit is itself select bit 0
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    capture   = 1'b0;
    sel_chk   = 1'b0;
    start     = 1'b0;
    overrun   = 1'b0;
    if (bit_ev) begin
      case (state)
        IDLE: begin
          start     = 1'b1;
          sel_chk   = 1'b1;
          state_nxt = DATA;
        end
        SEL: begin
          sel_chk   = 1'b1;
          state_nxt = DATA;
        end
        DATA: begin
          shift_en = 1'b1;
          if (pos == POS_W'(LED_WORD_W - 1)) begin
            capture = 1'b1;
            if (word_cnt == WORD_CNT_W'(WORDS_PER_CHIP - 1)) begin
              state_nxt = SEL;
            end else if (word_cnt == WORD_CNT_W'(WORDS_PER_LANE - 1)) begin
              state_nxt = FULL;
            end
          end
        end
        FULL: begin
          overrun = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
    if (lat_ev) begin
      state_nxt = IDLE;
    end
  end

  // Bit count including this cycle's bit, so a coincident LAT sees the final count
  always_comb begin
    bit_cnt_nxt = bit_cnt;
    if (start) begin
      bit_cnt_nxt = BIT_CNT_W'(1);
    end else if (bit_ev && (state == SEL || state == DATA)) begin
      bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Sticky error flags: frame start clears, overrun / bad count / nonzero select set
  always_comb begin
    err_nxt = start ? 1'b0 : frameErr;
    if (overrun || (lat_ev && bit_cnt_nxt != BIT_CNT_W'(BITS_PER_FRAME))) begin
      err_nxt = 1'b1;
    end
    sel_nxt = (start ? 1'b0 : selErr) | (sel_chk & (|sdi_q));
  end

  // Frame position counters; LAT rewinds them so a bare LAT reads as a short frame
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      pos      <= '0;
    end else if (lat_ev) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      pos      <= '0;
    end else begin
      bit_cnt <= bit_cnt_nxt;
      if (start) begin
        word_cnt <= '0;
        pos      <= '0;
      end else if (capture) begin
        word_cnt <= word_cnt + WORD_CNT_W'(1);
        pos      <= '0;
      end else if (shift_en) begin
        pos <= pos + POS_W'(1);
      end
    end
  end

  // Frame status outputs
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      busy      <= 1'b0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
      selErr    <= 1'b0;
    end else begin
      frameDone <= lat_ev;
      frameErr  <= err_nxt;
      selErr    <= sel_nxt;
      if (lat_ev) begin
        busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    led_lane_deser u_deser (
      .spiClk   (spiClk),
      .nReset   (nReset),
      .shift_en (shift_en),
      .capture  (capture),
      .sdi      (sdi_q[g]),
      .word     (lane_word[g])
    );
  end

  // Drain the holding bank one lane per cycle; LAT does not interrupt it
  always_ff @(posedge spiClk or negedge nReset) begin
    if (!nReset) begin
      drain_act  <= 1'b0;
      drain_lane <= '0;
      drain_word <= '0;
      wr.wrEn    <= 1'b0;
      wr.wrAddr  <= '0;
      wr.wrData  <= '0;
    end else begin
      wr.wrEn <= drain_act;
      if (drain_act) begin
        wr.wrAddr <= {drain_lane, drain_word};
        wr.wrData <= lane_word[drain_lane];
      end
      if (capture) begin
        drain_act  <= 1'b1;
        drain_lane <= '0;
        drain_word <= word_cnt;
      end else if (drain_act) begin
        drain_lane <= drain_lane + LANE_W'(1);
        if (drain_lane == LANE_W'(LANES - 1)) begin
          drain_act <= 1'b0;
        end
      end
    end
  end

endmodule
